sprite_store_ctrl: RTL and testbench
====================================

// Module: sprite_store_ctrl
// PURPOSE
// - Sequencer for the 10-slot sprite store (6-bit OAM index + 4-bit line per slot).
// - OAM scan phase: allocates slots in order and issues one-hot slot write strobes.
// - Render phase: arbitrates per-slot X-match hits, lowest slot first; hands one slot at a time to the sprite fetcher with req/ack.
// - Sits between the OAM scanner, the sprite store, the X comparators and the fetcher.
// PARAMETERS
// - NUM_SLOTS  10  store depth; 1..15
// - IDX_W      6   OAM sprite index width (oam_a[7:2])
// - LINE_W     4   sprite line-within-tile width
// PORTS
// - clk          in   1          single clock; everything rising-edge
// - nreset       in   1          reset, synchronous, active-low
// - scan_start   in   1          pulse: new line OAM scan begins
// - scan_hit     in   1          pulse: current OAM entry in range
// - scan_idx     in   IDX_W      index of hitting entry
// - scan_line    in   LINE_W     line of hitting entry
// - scan_done    in   1          pulse: scan finished
// - render_start in   1          pulse: pixel render begins
// - render_done  in   1          pulse: line render finished
// - x_match      in   NUM_SLOTS  per-slot X comparator hit
// - fetch_ack    in   1          fetcher consumed slot
// - store_wr     out  NUM_SLOTS  one-hot slot write strobe
// - wr_idx       out  IDX_W      data for store_wr
// - wr_line      out  LINE_W     data for store_wr
// - store_rd     out  NUM_SLOTS  one-hot slot bus-drive enable
// - fetch_req    out  1          slot ready for fetch
// - fetch_slot   out  4          binary slot number
// - stall        out  1          hold pixel pipe
// - count        out  4          slots filled this line
// - full         out  1          count == NUM_SLOTS
// - ovf          out  1          sticky: hit rejected while full
// - ovf_cnt      out  6          rejected hits this line
// BEHAVIOUR
// - Reset (nreset low at edge): state IDLE; all outputs 0; valid[] = 0. Reset mid-operation aborts at once; no strobe survives.
// - States: IDLE, SCAN, READY, RENDER, FETCH.
// - Any state, scan_start: next SCAN; valid, count, ovf, ovf_cnt cleared; store_rd and fetch_req drop next cycle. Beats all other inputs.
// - SCAN, scan_hit with count<NUM_SLOTS:
//   - next cycle store_wr[count]=1 for exactly 1 cycle, with wr_idx/wr_line registered.
//   - valid[count] set; count increments.
// - SCAN, scan_hit when full: no strobe; rejection counted (see CONFIGURATION).
// - SCAN, scan_done: next READY. Same-cycle scan_hit is still recorded.
// - READY, render_start: next RENDER. Other inputs ignored.
// - RENDER, m = x_match & valid nonzero:
//   - s = lowest set bit of m.
//   - Next cycle: fetch_req=1, stall=1, store_rd[s]=1, fetch_slot=s; state FETCH. Latency 1 cycle.
// - RENDER, render_done with m==0: next IDLE.
// - FETCH: outputs held stable until fetch_ack.
//   - On ack: valid[s] cleared; fetch_req, stall, store_rd drop next cycle; back to RENDER.
//   - Next hit is arbitrated no earlier than 1 cycle after ack, so ack-to-next-req is at least 2 cycles.
// - FETCH, render_done: latched, applied on return to RENDER.
// - FETCH, fetch_ack and scan_start same cycle: scan_start wins; valid cleared anyway.
// - x_match bits of invalid or already-fetched slots are ignored. Each slot is fetched at most once per line.
// - count saturates at NUM_SLOTS. ovf_cnt saturates at 63.
// CONFIGURATION
// - Macro SPRITE_STORE_OVF_EN:
//   - Defined: ovf sets on a rejected hit and clears on scan_start; ovf_cnt counts rejected hits.
//   - Undefined: ovf and ovf_cnt tied 0; no counter logic.
// STRUCTURE
// - Package sprite_store_pkg:
//   - NUM_SLOTS_DEF = 10, IDX_W_DEF = 6, LINE_W_DEF = 4.
//   - typedef enum logic [2:0] ss_state_t {IDLE, SCAN, READY, RENDER, FETCH}.
//   - typedef logic [NUM_SLOTS_DEF-1:0] slot_vec_t.
// - Sub-module sprite_prio_enc: NUM_SLOTS-wide lowest-bit-first priority encoder.
//   - Outputs: one-hot grant, binary index, any flag.
//   - Purely combinational.
// TESTING
// - Reset: nreset low 2 cycles mid-FETCH -> next cycle all outputs 0, state IDLE.
// - Scan fill: scan_start, 3 hits (idx 5,9,12; line 2,0,7) -> store_wr 001,010,100 each 1 cycle after its hit; wr_idx/wr_line match; count=3.
// - Overflow: 12 hits -> store_wr[0..9] once each; full=1, count=10; with OVF_EN ovf=1, ovf_cnt=2; without, both 0.
// - Arbitration: slots 0-3 valid, x_match=0b1010 -> fetch_slot=1, store_rd=0b0010; ack -> fetch_slot=3 two cycles later; then no request.
// - Held request: no fetch_ack for 20 cycles -> fetch_req, stall, store_rd stable throughout; render_done during FETCH -> IDLE after ack.
// - Abort: scan_start while FETCH -> fetch_req=0 next cycle, count=0, state SCAN; same-cycle scan_hit+scan_done -> hit recorded, READY.

Source files
------------

// File: rtl/sprite_store_pkg.sv
// rtl/sprite_store_pkg.sv - shared types and defaults for the sprite store sequencer
package sprite_store_pkg;

   localparam int NUM_SLOTS_DEF = 10;
   localparam int IDX_W_DEF     = 6;
   localparam int LINE_W_DEF    = 4;

   typedef enum logic [2:0] {IDLE, SCAN, READY, RENDER, FETCH} ss_state_t;

   typedef logic [NUM_SLOTS_DEF-1:0] slot_vec_t;

endpackage

// File: rtl/sprite_store_ctrl_if.sv
// rtl/sprite_store_ctrl_if.sv - scan/render/fetch bundle; master drives the controller, slave is the controller
interface sprite_store_ctrl_if #(
   parameter int NUM_SLOTS = 10,
   parameter int IDX_W     = 6,
   parameter int LINE_W    = 4
);
   logic                 scan_start;
   logic                 scan_hit;
   logic [IDX_W-1:0]     scan_idx;
   logic [LINE_W-1:0]    scan_line;
   logic                 scan_done;
   logic                 render_start;
   logic                 render_done;
   logic [NUM_SLOTS-1:0] x_match;
   logic                 fetch_ack;
   logic [NUM_SLOTS-1:0] store_wr;
   logic [IDX_W-1:0]     wr_idx;
   logic [LINE_W-1:0]    wr_line;
   logic [NUM_SLOTS-1:0] store_rd;
   logic                 fetch_req;
   logic [3:0]           fetch_slot;
   logic                 stall;
   logic [3:0]           count;
   logic                 full;
   logic                 ovf;
   logic [5:0]           ovf_cnt;

   modport master (
      output scan_start, scan_hit, scan_idx, scan_line, scan_done,
             render_start, render_done, x_match, fetch_ack,
      input  store_wr, wr_idx, wr_line, store_rd, fetch_req, fetch_slot,
             stall, count, full, ovf, ovf_cnt
   );

   modport slave (
      input  scan_start, scan_hit, scan_idx, scan_line, scan_done,
             render_start, render_done, x_match, fetch_ack,
      output store_wr, wr_idx, wr_line, store_rd, fetch_req, fetch_slot,
             stall, count, full, ovf, ovf_cnt
   );

endinterface

// File: rtl/sprite_prio_enc.sv
// rtl/sprite_prio_enc.sv - lowest-bit-first combinational priority encoder
module sprite_prio_enc #(
   parameter int N = 10
) (
   input  logic [N-1:0] req,
   output logic [N-1:0] grant,
   output logic [3:0]   idx,
   output logic         any
);

   // Scanning from the top down lets the lowest set bit overwrite last.
   always_comb begin
      grant = '0;
      idx   = '0;
      any   = 1'b0;
      for (int i = N - 1; i >= 0; i--) begin
         if (req[i]) begin
            grant    = '0;
            grant[i] = 1'b1;
            idx      = 4'(i);
            any      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/sprite_store_ctrl.sv
// rtl/sprite_store_ctrl.sv - sprite store scan/render sequencer; SPRITE_STORE_OVF_EN enables overflow tracking
module sprite_store_ctrl
   import sprite_store_pkg::*;
#(
   parameter int NUM_SLOTS = NUM_SLOTS_DEF,
   parameter int IDX_W     = IDX_W_DEF,
   parameter int LINE_W    = LINE_W_DEF
) (
   input logic                clk,
   input logic                nreset,
   sprite_store_ctrl_if.slave bus
);

   ss_state_t            state_q, state_d;
   logic [NUM_SLOTS-1:0] valid_q, valid_d;
   logic [3:0]           count_q, count_d;
   logic [NUM_SLOTS-1:0] store_wr_q, store_wr_d;
   logic [IDX_W-1:0]     wr_idx_q, wr_idx_d;
   logic [LINE_W-1:0]    wr_line_q, wr_line_d;
   logic [NUM_SLOTS-1:0] store_rd_q, store_rd_d;
   logic                 fetch_req_q, fetch_req_d;
   logic [3:0]           fetch_slot_q, fetch_slot_d;
   logic                 stall_q, stall_d;
   logic                 done_pend_q, done_pend_d;

   logic [NUM_SLOTS-1:0] grant;
   logic [3:0]           grant_idx;
   logic                 grant_any;

   sprite_prio_enc #(.N(NUM_SLOTS)) u_enc (
      .req   (bus.x_match & valid_q),
      .grant (grant),
      .idx   (grant_idx),
      .any   (grant_any)
   );

   always_comb begin
      state_d      = state_q;
      valid_d      = valid_q;
      count_d      = count_q;
      store_wr_d   = '0;
      wr_idx_d     = wr_idx_q;
      wr_line_d    = wr_line_q;
      store_rd_d   = store_rd_q;
      fetch_req_d  = fetch_req_q;
      fetch_slot_d = fetch_slot_q;
      stall_d      = stall_q;
      done_pend_d  = done_pend_q;
      if (bus.scan_start) begin
         state_d     = SCAN;
         valid_d     = '0;
         count_d     = '0;
         store_rd_d  = '0;
         fetch_req_d = 1'b0;
         stall_d     = 1'b0;
         done_pend_d = 1'b0;
      end else begin
         case (state_q)
            SCAN: begin
               if (bus.scan_hit && (count_q < 4'(NUM_SLOTS))) begin
                  store_wr_d[count_q] = 1'b1;
                  valid_d[count_q]    = 1'b1;
                  wr_idx_d            = bus.scan_idx;
                  wr_line_d           = bus.scan_line;
                  count_d             = count_q + 4'd1;
               end
               if (bus.scan_done) state_d = READY;
            end
            READY: if (bus.render_start) state_d = RENDER;
            RENDER: begin
               // A render_done alongside a live hit is kept so the line still ends.
               if (grant_any) begin
                  state_d      = FETCH;
                  fetch_req_d  = 1'b1;
                  stall_d      = 1'b1;
                  store_rd_d   = grant;
                  fetch_slot_d = grant_idx;
                  done_pend_d  = done_pend_q | bus.render_done;
               end else if (bus.render_done || done_pend_q) begin
                  state_d     = IDLE;
                  done_pend_d = 1'b0;
               end
            end
            FETCH: begin
               if (bus.render_done) done_pend_d = 1'b1;
               if (bus.fetch_ack) begin
                  valid_d[fetch_slot_q] = 1'b0;
                  fetch_req_d           = 1'b0;
                  stall_d               = 1'b0;
                  store_rd_d            = '0;
                  state_d               = RENDER;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!nreset) begin
         state_q      <= IDLE;
         valid_q      <= '0;
         count_q      <= '0;
         store_wr_q   <= '0;
         wr_idx_q     <= '0;
         wr_line_q    <= '0;
         store_rd_q   <= '0;
         fetch_req_q  <= 1'b0;
         fetch_slot_q <= '0;
         stall_q      <= 1'b0;
         done_pend_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         valid_q      <= valid_d;
         count_q      <= count_d;
         store_wr_q   <= store_wr_d;
         wr_idx_q     <= wr_idx_d;
         wr_line_q    <= wr_line_d;
         store_rd_q   <= store_rd_d;
         fetch_req_q  <= fetch_req_d;
         fetch_slot_q <= fetch_slot_d;
         stall_q      <= stall_d;
         done_pend_q  <= done_pend_d;
      end
   end

`ifdef SPRITE_STORE_OVF_EN
   logic       ovf_q, ovf_d;
   logic [5:0] ovf_cnt_q, ovf_cnt_d;

   always_comb begin
      ovf_d     = ovf_q;
      ovf_cnt_d = ovf_cnt_q;
      if (bus.scan_start) begin
         ovf_d     = 1'b0;
         ovf_cnt_d = '0;
      end else if ((state_q == SCAN) && bus.scan_hit && (count_q >= 4'(NUM_SLOTS))) begin
         ovf_d = 1'b1;
         if (ovf_cnt_q != 6'd63) ovf_cnt_d = ovf_cnt_q + 6'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!nreset) begin
         ovf_q     <= 1'b0;
         ovf_cnt_q <= '0;
      end else begin
         ovf_q     <= ovf_d;
         ovf_cnt_q <= ovf_cnt_d;
      end
   end

   assign bus.ovf     = ovf_q;
   assign bus.ovf_cnt = ovf_cnt_q;
`else
   assign bus.ovf     = 1'b0;
   assign bus.ovf_cnt = '0;
`endif

   assign bus.store_wr   = store_wr_q;
   assign bus.wr_idx     = wr_idx_q;
   assign bus.wr_line    = wr_line_q;
   assign bus.store_rd   = store_rd_q;
   assign bus.fetch_req  = fetch_req_q;
   assign bus.fetch_slot = fetch_slot_q;
   assign bus.stall      = stall_q;
   assign bus.count      = count_q;
   assign bus.full       = (count_q == 4'(NUM_SLOTS));

endmodule

// File: tb/tb_sprite_store_ctrl.sv
// tb/tb_sprite_store_ctrl.sv - randomized self-checking bench for sprite_store_ctrl
module tb_sprite_store_ctrl;
   import sprite_store_pkg::*;

   localparam int N = 10;

   logic clk = 1'b0;
   logic nreset = 1'b0;
   int   vecs = 0;
   int   errs = 0;

   always #5 clk = ~clk;

   sprite_store_ctrl_if #(.NUM_SLOTS(N), .IDX_W(6), .LINE_W(4)) sif ();

   sprite_store_ctrl #(.NUM_SLOTS(N), .IDX_W(6), .LINE_W(4)) dut (
      .clk    (clk),
      .nreset (nreset),
      .bus    (sif.slave)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clr_in();
      sif.scan_start = 0; sif.scan_hit = 0; sif.scan_idx = '0; sif.scan_line = '0;
      sif.scan_done = 0; sif.render_start = 0; sif.render_done = 0;
      sif.x_match = '0; sif.fetch_ack = 0;
   endtask

   task automatic fill(input int n);
      sif.scan_start = 1; tick(); sif.scan_start = 0;
      for (int i = 0; i < n; i++) begin
         sif.scan_hit = 1; sif.scan_idx = 6'($urandom); sif.scan_line = 4'($urandom);
         tick();
      end
      sif.scan_hit = 0;
      sif.scan_done = 1; tick(); sif.scan_done = 0;
      sif.render_start = 1; tick(); sif.render_start = 0;
   endtask

   task automatic test_reset();
      fill(1);
      sif.x_match = 10'b1; tick();
      vecs++; if (sif.fetch_req !== 1'b1) begin errs++; $display("FAIL reset_pre fetch_req got %b want 1", sif.fetch_req); end
      nreset = 0; tick();
      vecs++;
      if ({sif.store_wr, sif.wr_idx, sif.wr_line, sif.store_rd, sif.fetch_req, sif.fetch_slot,
           sif.stall, sif.count, sif.full, sif.ovf, sif.ovf_cnt} !== 48'h0) begin
         errs++; $display("FAIL reset_outs fetch_req=%b store_rd=%h count=%0d want all 0", sif.fetch_req, sif.store_rd, sif.count);
      end
      tick(); nreset = 1; sif.x_match = '0; tick();
      vecs++; if (dut.state_q !== IDLE) begin errs++; $display("FAIL reset_state got %0d want IDLE", dut.state_q); end
      vecs++; if ({sif.fetch_req, sif.stall, sif.store_rd, sif.count} !== 16'h0) begin
         errs++; $display("FAIL reset_hold fetch_req=%b stall=%b want 0", sif.fetch_req, sif.stall);
      end
   endtask

   task automatic test_scan_fill();
      logic [5:0] idxs [3] = '{6'd5, 6'd9, 6'd12};
      logic [3:0] lines[3] = '{4'd2, 4'd0, 4'd7};
      logic [N-1:0] exp_wr;
      sif.scan_start = 1; tick(); sif.scan_start = 0;
      for (int k = 0; k < 3; k++) begin
         sif.scan_hit = 1; sif.scan_idx = idxs[k]; sif.scan_line = lines[k];
         tick();
         sif.scan_hit = 0;
         exp_wr = '0; exp_wr[k] = 1'b1;
         vecs++; if (sif.store_wr !== exp_wr) begin errs++; $display("FAIL fill_wr%0d got %b want %b", k, sif.store_wr, exp_wr); end
         vecs++; if ({sif.wr_idx, sif.wr_line} !== {idxs[k], lines[k]}) begin
            errs++; $display("FAIL fill_data%0d got %0d/%0d want %0d/%0d", k, sif.wr_idx, sif.wr_line, idxs[k], lines[k]);
         end
         tick();
         vecs++; if (sif.store_wr !== '0) begin errs++; $display("FAIL fill_pulse%0d got %b want 0", k, sif.store_wr); end
      end
      vecs++; if (sif.count !== 4'd3) begin errs++; $display("FAIL fill_count got %0d want 3", sif.count); end
   endtask

   task automatic test_overflow();
      int hits = 0;
      int rej;
      logic [N-1:0] exp_wr;
      logic [5:0] ri;
      logic [3:0] rl;
      sif.scan_start = 1; tick(); sif.scan_start = 0;
      for (int k = 0; k < 12; k++) begin
         ri = 6'($urandom); rl = 4'($urandom);
         sif.scan_hit = 1; sif.scan_idx = ri; sif.scan_line = rl;
         tick();
         exp_wr = '0; if (hits < N) exp_wr[hits] = 1'b1;
         vecs++; if (sif.store_wr !== exp_wr) begin errs++; $display("FAIL ovf_wr%0d got %b want %b", k, sif.store_wr, exp_wr); end
         if (hits < N) begin
            vecs++; if ({sif.wr_idx, sif.wr_line} !== {ri, rl}) begin
               errs++; $display("FAIL ovf_data%0d got %0d/%0d want %0d/%0d", k, sif.wr_idx, sif.wr_line, ri, rl);
            end
         end
         hits++;
      end
      sif.scan_hit = 0; tick();
      rej = hits - N;
      vecs++; if ({sif.full, sif.count} !== {1'b1, 4'(N)}) begin errs++; $display("FAIL ovf_full got %b/%0d want 1/%0d", sif.full, sif.count, N); end
`ifdef SPRITE_STORE_OVF_EN
      vecs++; if ({sif.ovf, sif.ovf_cnt} !== {1'b1, 6'(rej)}) begin errs++; $display("FAIL ovf_flag got %b/%0d want 1/%0d", sif.ovf, sif.ovf_cnt, rej); end
      sif.scan_hit = 1; repeat (70) tick(); sif.scan_hit = 0; tick();
      rej = rej + 70;
      vecs++; if (sif.ovf_cnt !== 6'((rej > 63) ? 63 : rej)) begin errs++; $display("FAIL ovf_sat got %0d want 63", sif.ovf_cnt); end
`else
      vecs++; if ({sif.ovf, sif.ovf_cnt} !== 7'h0) begin errs++; $display("FAIL ovf_flag got %b/%0d want 0/0 (rej %0d)", sif.ovf, sif.ovf_cnt, rej); end
`endif
   endtask

   task automatic test_arbitration();
      fill(4);
      sif.x_match = 10'b1010; tick();
      vecs++; if ({sif.fetch_req, sif.stall, sif.fetch_slot, sif.store_rd} !== {1'b1, 1'b1, 4'd1, 10'b0010}) begin
         errs++; $display("FAIL arb_first req=%b slot=%0d rd=%b want 1/1/0010", sif.fetch_req, sif.fetch_slot, sif.store_rd);
      end
      sif.fetch_ack = 1; tick(); sif.fetch_ack = 0;
      vecs++; if (sif.fetch_req !== 1'b0) begin errs++; $display("FAIL arb_drop got %b want 0", sif.fetch_req); end
      tick();
      vecs++; if ({sif.fetch_req, sif.fetch_slot, sif.store_rd} !== {1'b1, 4'd3, 10'b1000}) begin
         errs++; $display("FAIL arb_second req=%b slot=%0d rd=%b want 1/3/1000", sif.fetch_req, sif.fetch_slot, sif.store_rd);
      end
      sif.fetch_ack = 1; tick(); sif.fetch_ack = 0; tick(); tick();
      vecs++; if (sif.fetch_req !== 1'b0) begin errs++; $display("FAIL arb_none got %b want 0", sif.fetch_req); end
      sif.x_match = '0;
   endtask

   task automatic test_held_request();
      fill(3);
      sif.x_match = 10'b110; tick();
      for (int c = 0; c < 20; c++) begin
         sif.x_match = 10'($urandom);
         sif.render_done = (c == 5);
         tick();
         vecs++; if ({sif.fetch_req, sif.stall, sif.fetch_slot, sif.store_rd} !== {1'b1, 1'b1, 4'd1, 10'b0010}) begin
            errs++; $display("FAIL held_c%0d req=%b stall=%b slot=%0d rd=%b", c, sif.fetch_req, sif.stall, sif.fetch_slot, sif.store_rd);
         end
      end
      sif.render_done = 0; sif.x_match = '0;
      sif.fetch_ack = 1; tick(); sif.fetch_ack = 0;
      vecs++; if ({sif.fetch_req, sif.stall, sif.store_rd} !== 12'h0) begin errs++; $display("FAIL held_drop req=%b want 0", sif.fetch_req); end
      tick();
      vecs++; if (dut.state_q !== IDLE) begin errs++; $display("FAIL held_idle got %0d want IDLE", dut.state_q); end
   endtask

   task automatic test_abort();
      fill(2);
      sif.x_match = 10'b01; tick();
      sif.x_match = '0;
      sif.scan_start = 1; sif.fetch_ack = 1; tick(); sif.scan_start = 0; sif.fetch_ack = 0;
      vecs++; if ({sif.fetch_req, sif.stall, sif.store_rd, sif.count} !== 16'h0) begin
         errs++; $display("FAIL abort_outs req=%b count=%0d want 0", sif.fetch_req, sif.count);
      end
      vecs++; if (dut.state_q !== SCAN) begin errs++; $display("FAIL abort_state got %0d want SCAN", dut.state_q); end
      sif.scan_hit = 1; sif.scan_done = 1; sif.scan_idx = 6'd33; sif.scan_line = 4'd9; tick();
      sif.scan_hit = 0; sif.scan_done = 0;
      vecs++; if ({sif.store_wr, sif.wr_idx} !== {10'b1, 6'd33}) begin errs++; $display("FAIL abort_hit got %b/%0d want 1/33", sif.store_wr, sif.wr_idx); end
      vecs++; if (dut.state_q !== READY) begin errs++; $display("FAIL abort_ready got %0d want READY", dut.state_q); end
      tick();
      vecs++; if (sif.count !== 4'd1) begin errs++; $display("FAIL abort_count got %0d want 1", sif.count); end
   endtask

   task automatic test_random_render();
      logic [N-1:0] rem, x, exp_rd;
      int n, found, d;
      for (int t = 0; t < 4; t++) begin
         n = $urandom_range(1, N);
         fill(n);
         rem = '0;
         for (int i = 0; i < n; i++) rem[i] = 1'b1;
         for (int it = 0; it < 15; it++) begin
            x = 10'($urandom);
            sif.x_match = x; tick();
            found = -1;
            for (int i = 0; i < N && found < 0; i++) if (x[i] && rem[i]) found = i;
            if (found >= 0) begin
               rem[found] = 1'b0;
               exp_rd = '0; exp_rd[found] = 1'b1;
               d = $urandom_range(0, 3);
               for (int w = 0; w <= d; w++) begin
                  vecs++; if ({sif.fetch_req, sif.stall, sif.fetch_slot, sif.store_rd} !== {1'b1, 1'b1, 4'(found), exp_rd}) begin
                     errs++; $display("FAIL rnd_fetch t%0d it%0d slot=%0d rd=%b want %0d/%b", t, it, sif.fetch_slot, sif.store_rd, found, exp_rd);
                  end
                  if (w < d) begin sif.x_match = 10'($urandom); tick(); end
               end
               sif.fetch_ack = 1; tick(); sif.fetch_ack = 0;
               vecs++; if (sif.fetch_req !== 1'b0) begin errs++; $display("FAIL rnd_drop t%0d it%0d got %b want 0", t, it, sif.fetch_req); end
            end else begin
               vecs++; if (sif.fetch_req !== 1'b0) begin errs++; $display("FAIL rnd_idle t%0d it%0d got %b want 0", t, it, sif.fetch_req); end
            end
         end
         sif.x_match = '0; sif.render_done = 1; tick(); sif.render_done = 0;
         vecs++; if (dut.state_q !== IDLE) begin errs++; $display("FAIL rnd_end t%0d got %0d want IDLE", t, dut.state_q); end
      end
   endtask

   initial begin
      clr_in();
      nreset = 0; tick(); tick(); nreset = 1; tick();
      test_reset();
      test_scan_fill();
      test_overflow();
      test_arbitration();
      test_held_request();
      test_abort();
      test_random_render();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
